// File: rtl/dot_seq_pkg.sv
// Shared constants for the dot-product sequencer: FSM state encoding and
// the mode codes understood by the 3-input MAC unit.
package dot_seq_pkg;

  // Controller states (2-bit encoding, exposed on dbg_state)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  // MAC operating modes
  localparam logic [1:0] MODE_ADD = 2'b00;  // dout <- a + b
  localparam logic [1:0] MODE_MAC = 2'b01;  // dout <- a * b + c
  localparam logic [1:0] MODE_MUL = 2'b10;  // dout <- a * b (2'b11 behaves the same)

endpackage

// File: rtl/dot_seq_mac.sv
// Registered 3-input multiply-accumulate unit. All arithmetic wraps modulo
// 2^bw; the output register is the only storage and serves as the
// accumulator for the sequencer above it.
module dot_seq_mac #(
  parameter int bw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [bw-1:0] din_a,
  input  logic [bw-1:0] din_b,
  input  logic [bw-1:0] din_c,
  output logic [bw-1:0] dout
);

  logic [bw-1:0] dout_nxt;

  // Select the operation from the mode code; mode[1] set means plain multiply
  always_comb begin
    if (mode[1]) begin
      dout_nxt = din_a * din_b;
    end else if (mode[0]) begin
      dout_nxt = din_a * din_b + din_c;
    end else begin
      dout_nxt = din_a + din_b;
    end
  end

  // Output register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else begin
      dout <= dout_nxt;
    end
  end

endmodule

// File: rtl/dot_seq.sv
// Dot-product sequencer: accepts len operand pairs and accumulates a*b in
// the MAC output register, then publishes the truncated sum with a
// one-cycle done pulse.
//
// Operand handshake: a pair (op_a, op_b) is consumed on a rising clk edge
// where op_valid & op_ready are both high. op_ready depends only on the
// registered state (high only in ACC), never on op_valid. The source must
// hold op_valid and the operands stable until that edge; op_valid outside
// ACC is ignored.
module dot_seq
  import dot_seq_pkg::*;
#(
  parameter int BW    = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             op_valid,
  input  logic [BW-1:0]    op_a,
  input  logic [BW-1:0]    op_b,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic [BW-1:0]    result,
  output logic [1:0]       dbg_state
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic [1:0]       mac_mode;
  logic [BW-1:0]    mac_a;
  logic [BW-1:0]    mac_b;
  logic [BW-1:0]    mac_c;
  logic [BW-1:0]    mac_dout;
  logic             fire;

  assign op_ready  = (state == ST_ACC);
  assign busy      = (state != ST_IDLE);
  assign fire      = op_valid & op_ready;
  assign dbg_state = state;

  // Next state, remaining-element count and MAC configuration. The default
  // configuration (add zero to the current output) holds the accumulator.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mac_mode  = MODE_ADD;
    mac_a     = mac_dout;
    mac_b     = '0;
    mac_c     = mac_dout;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cnt_nxt   = len;
          state_nxt = ST_CLR;
        end
      end
      ST_CLR: begin
        mac_mode  = MODE_MUL;
        mac_a     = '0;
        state_nxt = (cnt == '0) ? ST_FIN : ST_ACC;
      end
      ST_ACC: begin
        if (fire) begin
          mac_mode = MODE_MAC;
          mac_a    = op_a;
          mac_b    = op_b;
          cnt_nxt  = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) begin
            state_nxt = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and down-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Publish the sum when leaving FIN; done is high for exactly one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= (state == ST_FIN);
      if (state == ST_FIN) begin
        result <= mac_dout;
      end
    end
  end

  dot_seq_mac #(
    .bw(BW)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .mode (mac_mode),
    .din_a(mac_a),
    .din_b(mac_b),
    .din_c(mac_c),
    .dout (mac_dout)
  );

endmodule

// File: tb/tb_dot_seq.sv
// Bench for dot_seq: directed scenarios plus randomized runs. Expected
// sums come from plain integer arithmetic modulo 256 and expected latency
// from the element count plus the stall cycles the driver inserts.
module tb_dot_seq;
  import dot_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       op_valid;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_ready;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [1:0] dbg_state;

  int total;
  int bad;

  logic [7:0] va[64];
  logic [7:0] vb[64];
  int         gap[64];

  dot_seq #(
    .BW   (8),
    .LEN_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .op_valid (op_valid),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_ready (op_ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: dot product of the first n pairs, wrapped to 8 bits
  function automatic int ref_dot(input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      s = (s + int'(va[i]) * int'(vb[i])) % 256;
    end
    return s;
  endfunction

  // Drive one run of n pairs from va/vb with gap[i] idle cycles before pair
  // i (i >= 1). inj_k >= 0 re-pulses start before edge E(inj_k). With chain
  // set, returns in the done cycle so the caller can start again there.
  task automatic run_vec(input int n, input int inj_k, input bit chain);
    int   gap_sum, exp_lat, k, idx, gap_left, ready_cycles, done_at, exp_sum;
    bit   hs;
    gap_sum = 0;
    for (int i = 1; i < n; i++) gap_sum += gap[i];
    exp_lat = n + 2 + gap_sum;
    exp_sum = ref_dot(n);

    start = 1'b1;
    len   = 8'(n);
    idx = 0; gap_left = 0; k = 0; ready_cycles = 0; done_at = -1;
    // pair offered already in the CLR cycle; it must wait for ACC
    op_valid = (n > 0);
    op_a = va[0];
    op_b = vb[0];
    while (done_at < 0 && k <= exp_lat + 8) begin
      if (op_ready) ready_cycles++;
      hs = op_valid && op_ready;
      if (k == inj_k) begin
        start = 1'b1;
        len   = 8'd1;
      end
      step();
      start = 1'b0;
      if (k == 0) chk("busy_after_start", 32'(busy), 32'd1);
      if (done) done_at = k;
      k++;
      if (hs) begin
        idx++;
        if (idx < n) gap_left = gap[idx];
      end else if (gap_left > 0) begin
        gap_left--;
      end
      if (idx < n && gap_left == 0) begin
        op_valid = 1'b1;
        op_a = va[idx];
        op_b = vb[idx];
      end else if (idx < n) begin
        op_valid = 1'b0;
        op_a = 8'($urandom);
        op_b = 8'($urandom);
      end else begin
        // all pairs sent: junk outside ACC must be ignored
        op_valid = 1'($urandom_range(0, 1));
        op_a = 8'($urandom);
        op_b = 8'($urandom);
      end
    end
    op_valid = 1'b0;
    chk("done_latency", 32'(done_at), 32'(exp_lat));
    chk("result", 32'(result), 32'(exp_sum));
    chk("ready_cycles", 32'(ready_cycles), 32'(n + gap_sum));
    chk("busy_at_done", 32'(busy), 32'd0);
    if (!chain) begin
      step();
      chk("done_pulse_width", 32'(done), 32'd0);
      chk("result_hold", 32'(result), 32'(exp_sum));
    end
  endtask

  task automatic load3(input logic [7:0] a0, input logic [7:0] b0,
                       input logic [7:0] a1, input logic [7:0] b1,
                       input logic [7:0] a2, input logic [7:0] b2, input int g);
    va[0] = a0; vb[0] = b0; va[1] = a1; vb[1] = b1; va[2] = a2; vb[2] = b2;
    gap[0] = 0; gap[1] = g; gap[2] = g;
  endtask

  initial begin
    int hs_n, n, inj;
    bit ch;
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    #12;
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    rst = 1'b0;
    step();

    // back-to-back 3-element vector: 2*3+4*5+1*7 = 33
    load3(8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd7, 0);
    run_vec(3, -1, 1'b0);
    chk("dir_b2b_sum", 32'(result), 32'd33);

    // same vector with two idle cycles between pairs
    load3(8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd7, 2);
    run_vec(3, -1, 1'b0);

    // wraparound: 16*16 = 256 -> 0, plus 15
    va[0] = 8'd16; vb[0] = 8'd16; va[1] = 8'd3; vb[1] = 8'd5;
    gap[1] = 0;
    run_vec(2, -1, 1'b0);
    chk("dir_wrap_sum", 32'(result), 32'd15);

    // empty vector
    run_vec(0, -1, 1'b0);

    // start during ACC is ignored, then a new run launched in the done cycle
    for (int i = 0; i < 5; i++) begin
      va[i] = 8'(i + 1); vb[i] = 8'(2 * i + 3); gap[i] = 0;
    end
    run_vec(5, 3, 1'b1);
    load3(8'd2, 8'd3, 8'd4, 8'd5, 8'd1, 8'd7, 0);
    run_vec(3, -1, 1'b0);

    // reset after 2 of 4 pairs, with a pair still on offer
    start = 1'b1;
    len = 8'd4;
    step();
    start = 1'b0;
    op_valid = 1'b1;
    op_a = 8'd10;
    op_b = 8'd10;
    hs_n = 0;
    for (int k = 0; k < 20 && hs_n < 2; k++) begin
      if (op_ready && op_valid) hs_n++;
      step();
    end
    chk("rst_mid_pairs", 32'(hs_n), 32'd2);
    rst = 1'b1;
    #2;
    chk("arst_op_ready", 32'(op_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    rst = 1'b0;
    op_valid = 1'b0;
    step();
    va[0] = 8'd9; vb[0] = 8'd9;
    run_vec(1, -1, 1'b0);
    chk("post_rst_sum", 32'(result), 32'd81);

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      n = (r % 8 == 7) ? $urandom_range(20, 60) : $urandom_range(0, 12);
      for (int i = 0; i < 64; i++) begin
        va[i] = 8'($urandom);
        vb[i] = 8'($urandom);
        gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      end
      gap[0] = 0;
      inj = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 1) : -1;
      ch = ($urandom_range(0, 3) == 0);
      run_vec(n, inj, ch);
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_seq.md
# dot_seq

Sequencing controller that computes an unsigned dot product of length `len` on one 3-input MAC unit. It accepts operand pairs over a valid/ready stream and drives the MAC in multiply-accumulate mode, feeding the MAC output back as the addend. It returns the truncated `BW`-bit sum with a one-cycle `done` pulse. It sits between an operand source (FIFO or SPI/PIO bridge on the Pico side) and the result register bank.

## Interface
- `BW`, 8, operand/accumulator width; also the MAC `bw`.
- `LEN_W`, 8, width of the length field; max vector length is 2^LEN_W−1.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `start`  in  1  begin a dot product; sampled only in IDLE
- `len`  in  LEN_W  element count; latched when `start` is accepted
- `op_valid`  in  1  operand pair present
- `op_a`  in  BW  operand A
- `op_b`  in  BW  operand B
- `op_ready`  out  1  pair accepted on a clock edge where `op_valid & op_ready`
- `busy`  out  1  high in every state other than IDLE
- `done`  out  1  registered one-cycle pulse; `result` is valid while it is high
- `result`  out  BW  last completed dot product; holds until the next completion

## Operation
- Internal MAC modes:
  - `00`: dout ← a+b
  - `01`: dout ← a*b+c
  - `1x`: dout ← a*b
  - The MAC output register (1-cycle latency) is the accumulator; there is no separate acc register.
- States: IDLE, CLR, ACC, FIN.
- IDLE:
  - `op_ready`=0.
  - MAC held with mode `00`, a=mac_dout, b=0.
  - If `start` is high, latch `cnt`←`len` and go to CLR.
- CLR (1 cycle):
  - Drive mode `10`, a=0, b=0, which clears mac_dout.
  - Go to FIN if `cnt`==0, else ACC.
- ACC:
  - `op_ready`=1.
  - On handshake: mode `01`, a=`op_a`, b=`op_b`, c=mac_dout; `cnt`←`cnt`−1; go to FIN if `cnt`==1.
  - With no handshake: hold config (mode `00`, a=mac_dout, b=0), so gaps never corrupt the sum.
- FIN (1 cycle):
  - `op_ready`=0, MAC held.
  - At the exit edge: `result`←mac_dout, `done`←1. Go to IDLE.
- `done` clears on the following edge.
- Arithmetic: products and sums are truncated modulo 2^BW, with no saturation and no overflow flag.
- `start` while `busy`=1 is ignored and not queued.
- `start` in the IDLE cycle where `done`=1 is accepted normally.
- `op_valid` outside ACC is ignored; no pair is consumed.

## Timing
- Reset values: `op_ready`=0, `busy`=0, `done`=0, `result`=0, state=IDLE, `cnt`=0, MAC dout=0.
- Reset mid-operation aborts immediately:
  - No `done`, `result` returns to 0.
  - Any pair presented in that cycle is not consumed.
- Let E0 be the edge where `start` is accepted:
  - E1: enters ACC.
  - With back-to-back pairs: pairs are accepted at E2…E(N+1).
  - `done`=1 in the cycle after E(N+2).
  - Total latency is N+2 cycles; each stall cycle adds one.
- `len`=0: `done` after E2, `result`=0.
- `busy` rises after E0 and falls after E(N+2), together with `done` rising.
- Throughput: one pair per clock in ACC.

## Structure
- Shared package `dot_seq_pkg` holds:
  - State encoding (2-bit: IDLE, CLR, ACC, FIN).
  - MAC mode constants `MODE_ADD`=2'b00, `MODE_MAC`=2'b01, `MODE_MUL`=2'b10.
- One sub-module: the existing 3-input MAC unit (registered, async reset), instantiated with `bw`=`BW`. The controller drives its mode/din_a/din_b/din_c and reads dout.
- Down-counter `cnt` and FSM stay inline.

## Test plan
- `len`=3; pairs (2,3),(4,5),(1,7) back-to-back → `result`=33, `done` exactly 5 cycles after the start edge, `op_ready` high exactly 3 cycles.
- Same vector with `op_valid` low for 2 cycles between each pair → `result`=33, `done` delayed by 4 cycles, no spurious accumulation.
- BW=8, `len`=2, pairs (16,16),(3,5) → `result`=15 (256 wraps to 0).
- `len`=0 → `done` 2 cycles after start, `result`=0, `op_ready` never asserted.
- `start` pulsed during ACC with `len`=5 → ignored; the current run completes with the original length. A second `start` in the `done` cycle launches a new run.
- `rst` asserted after 2 of 4 pairs → all outputs reach reset values asynchronously. A following run with `len`=1, (9,9) → `result`=81 (no residue).
